clk_div_n: RTL and testbench
============================

// Module: clk_div_n
// PURPOSE
//   Runtime-programmable integer clock divider, N in [2, 2**DIV_W-1], exact 50% duty for odd and even N.
//   Successor to the fixed divide-by-3 block: generic divisor, enable, glitch-free divisor reload at period boundary.
//   Sits in clock-generation logic; clk_out feeds low-rate peripherals, tick is a clk-domain period strobe.
// PARAMETERS
//   DIV_W    8  width of divisor and counter
//   DEF_DIV  3  active divisor after reset (must be >= 2)
// PORTS
//   clk         in   1      source clock; both edges used
//   reset       in   1      asynchronous, active-low reset
//   en          in   1      run request; sampled on clk posedge
//   div_val     in   DIV_W  new divisor, captured when div_load=1
//   div_load    in   1      1-cycle load strobe (posedge domain)
//   clk_out     out  1      divided clock, 50% duty
//   tick        out  1      1-cycle pulse, clk domain, at each period start
//   div_ack     out  1      1-cycle pulse when pending divisor becomes active
//   running     out  1      1 while divider is in RUN
//   div_active  out  DIV_W  divisor currently in effect
// BEHAVIOUR
//   Reset (reset=0, async, immediate): cnt=0, pos_q=0, neg_q=0, clk_out=0, tick=0, div_ack=0,
//     running=0, div_active=DEF_DIV, pending flag=0, state=IDLE. All flops async-cleared, incl. negedge flop.
//   Clamp: any captured divisor <2 (0 or 1) is stored as 2.
//   H = N>>1 (even N) or (N-1)>>1 (odd N); odd = div_active[0].
//   posedge flops: cnt (0..N-1), pos_q; pos_q <= (cnt_next < H) in RUN, else 0.
//   negedge flop: neg_q <= pos_q when odd, else 0.
//   clk_out = pos_q | neg_q. Even N: high N/2 clk cycles. Odd N: high (N-1)/2 + 0.5 = N/2 cycles.
//   clk_out rising edge always follows a clk posedge (clk-to-q only).
//   FSM IDLE: cnt=0, pos_q=0. en=1 at posedge -> RUN; same edge: cnt<=0, pos_q<=1, tick<=1.
//   FSM RUN: cnt wraps N-1 -> 0; tick=1 on cycles where cnt_next=0.
//     At wrap, en=0 -> IDLE (current period always completes; clk_out never truncated by en).
//     At wrap, en=1 -> next period starts seamlessly, no idle cycle.
//   Divisor load: div_load=1 captures clamp(div_val) into pending reg, sets pending flag; later load
//     before boundary overwrites pending value (last write wins).
//   Apply point: wrap in RUN, or any posedge in IDLE. div_active<=pending, div_ack=1 for that cycle,
//     pending cleared. div_load on the same apply cycle: new value goes to pending, applied next boundary.
//   Glitch-free switch: cycle cnt=N-1 always has pos_q=0 and neg_q=0, so odd<->even changes never
//     produce a runt pulse.
//   running = (state==RUN). div_active constant within a period.
//   Mid-operation reset: clk_out drops to 0 asynchronously; restart needs en after reset release.
// TESTING
//   DEF_DIV=3, en=1 from cycle 0 -> clk_out period 3 clk, high 1.5 clk; tick every 3rd cycle; running=1.
//   Load div_val=4 mid-period -> div_ack at next wrap; then period 4, high exactly 2 clk; no runt at switch.
//   Load 5 then 8 in same period -> only 8 applied, single div_ack; period 8, high 4.
//   div_val=0 and div_val=1 -> div_active=2; clk_out = clk/2, 50% duty; div_val=255 (DIV_W=8) -> high 127.5 clk.
//   Drop en at cnt=1 of N=6 -> clk_out completes full period (3 high, 3 low), then stays 0, running=0.
//   Assert reset while clk_out=1 (N=7) -> clk_out=0 same timestep, div_active=DEF_DIV, tick=0; restarts on en.

Source files
------------

// File: rtl/clk_div_n_if.sv
// rtl/clk_div_n_if.sv - control/status bundle for the programmable clock divider
`timescale 1ns/1ps

interface clk_div_n_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_ack;
    logic             running;
    logic [DIV_W-1:0] div_active;

    // Controller side: drives run request and divisor loads, observes status
    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, div_ack, running, div_active
    );

    // Divider side
    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, div_ack, running, div_active
    );
endinterface

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - runtime-programmable 50% duty integer clock divider
`timescale 1ns/1ps

module clk_div_n #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic        clk,
    input  logic        reset,
    clk_div_n_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;

    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_inc;
    logic             wrap;
    logic             apply;

    // Divisors below 2 cannot produce a toggling output, so they become 2
    function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    // High-phase length in whole cycles; the odd half cycle comes from neg_q
    assign half    = div_active_q >> 1;
    assign cnt_inc = cnt_q + DIV_W'(1);
    assign wrap    = (cnt_q == div_active_q - DIV_W'(1));
    // Divisor may only change at a period boundary or while stopped
    assign apply   = (state_q == IDLE) || wrap;

    // Next-state, counter, divisor reload and strobe generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pos_d        = 1'b0;
        tick_d       = 1'b0;
        ack_d        = 1'b0;
        div_active_d = div_active_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                    pos_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (bus.en) begin
                        pos_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = (cnt_inc < half);
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply && pend_vld_q) begin
            div_active_d = pend_q;
            ack_d        = 1'b1;
            pend_vld_d   = 1'b0;
        end

        // A load on the apply cycle itself waits for the following boundary
        if (bus.div_load) begin
            pend_d     = clamp(bus.div_val);
            pend_vld_d = 1'b1;
        end
    end

    // Posedge state: FSM, counter, high phase, strobes, divisor registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pos_q        <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
            div_active_q <= DIV_W'(DEF_DIV);
            pend_q       <= DIV_W'(DEF_DIV);
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
            div_active_q <= div_active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    // Negedge copy of the high phase stretches it by half a cycle for odd N
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= div_active_q[0] ? pos_q : 1'b0;
        end
    end

    assign bus.clk_out    = pos_q | neg_q;
    assign bus.tick       = tick_q;
    assign bus.div_ack    = ack_q;
    assign bus.running    = (state_q == RUN);
    assign bus.div_active = div_active_q;

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - directed self-checking bench for clk_div_n
`timescale 1ns/1ps

module tb_clk_div_n;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    clk_div_n_if #(.DIV_W(8)) bus ();

    clk_div_n #(.DIV_W(8), .DEF_DIV(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next posedge that carries a tick; ok=0 if none within max cycles
    task automatic wait_tick(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk) #1;
            if (bus.tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sample clk_out every half cycle over n cycles, starting at a period-start sample
    task automatic measure(input int n, input int drop_at,
                           output int highs, output int ticks,
                           output int rises, output int acks);
        logic prev;
        prev  = 1'b0;
        highs = 0;
        ticks = 0;
        rises = 0;
        acks  = 0;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) bus.en = 1'b0;
            if (bus.clk_out) highs++;
            if (bus.clk_out && !prev) rises++;
            prev = bus.clk_out;
            if (bus.tick) ticks++;
            if (bus.div_ack) acks++;
            @(negedge clk) #1;
            if (bus.clk_out) highs++;
            if (bus.clk_out && !prev) rises++;
            prev = bus.clk_out;
            @(posedge clk) #1;
        end
    endtask

    task automatic load_div(input logic [7:0] v);
        bus.div_val  = v;
        bus.div_load = 1'b1;
        @(posedge clk) #1;
        bus.div_load = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.clk_out !== 1'b0) $display("FAIL reset_clk_out got=%b exp=0", bus.clk_out); else passed++;
        total++; if (bus.tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", bus.tick); else passed++;
        total++; if (bus.div_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus.div_ack); else passed++;
        total++; if (bus.running !== 1'b0) $display("FAIL reset_running got=%b exp=0", bus.running); else passed++;
        total++; if (bus.div_active !== 8'd3) $display("FAIL reset_div_active got=%0d exp=3", bus.div_active); else passed++;
    endtask

    task automatic test_div3();
        bit ok;
        int h, t, r, a;
        bus.en = 1'b1;
        wait_tick(4, ok);
        total++; if (ok !== 1'b1) $display("FAIL div3_start_tick got=%b exp=1", ok); else passed++;
        total++; if (bus.running !== 1'b1) $display("FAIL div3_running got=%b exp=1", bus.running); else passed++;
        measure(3, -1, h, t, r, a);
        total++; if (h !== 3) $display("FAIL div3_high_halves got=%0d exp=3", h); else passed++;
        total++; if (t !== 1) $display("FAIL div3_ticks got=%0d exp=1", t); else passed++;
        total++; if (r !== 1) $display("FAIL div3_rises got=%0d exp=1", r); else passed++;
        total++; if (bus.tick !== 1'b1) $display("FAIL div3_next_tick got=%b exp=1", bus.tick); else passed++;
    endtask

    task automatic test_load4();
        bit ok;
        int h, t, r, a;
        load_div(8'd4);
        wait_tick(4, ok);
        total++; if (ok !== 1'b1) $display("FAIL load4_tick got=%b exp=1", ok); else passed++;
        total++; if (bus.div_ack !== 1'b1) $display("FAIL load4_ack got=%b exp=1", bus.div_ack); else passed++;
        total++; if (bus.div_active !== 8'd4) $display("FAIL load4_active got=%0d exp=4", bus.div_active); else passed++;
        measure(4, -1, h, t, r, a);
        total++; if (h !== 4) $display("FAIL load4_high_halves got=%0d exp=4", h); else passed++;
        total++; if (t !== 1) $display("FAIL load4_ticks got=%0d exp=1", t); else passed++;
        total++; if (r !== 1) $display("FAIL load4_rises got=%0d exp=1", r); else passed++;
        total++; if (a !== 1) $display("FAIL load4_acks got=%0d exp=1", a); else passed++;
    endtask

    task automatic test_last_write_wins();
        bit ok;
        int h, t, r, a;
        load_div(8'd5);
        load_div(8'd8);
        wait_tick(4, ok);
        total++; if (ok !== 1'b1) $display("FAIL lww_tick got=%b exp=1", ok); else passed++;
        total++; if (bus.div_active !== 8'd8) $display("FAIL lww_active got=%0d exp=8", bus.div_active); else passed++;
        measure(8, -1, h, t, r, a);
        total++; if (h !== 8) $display("FAIL lww_high_halves got=%0d exp=8", h); else passed++;
        total++; if (a !== 1) $display("FAIL lww_acks_first got=%0d exp=1", a); else passed++;
        measure(8, -1, h, t, r, a);
        total++; if (a !== 0) $display("FAIL lww_acks_second got=%0d exp=0", a); else passed++;
        total++; if (t !== 1) $display("FAIL lww_ticks got=%0d exp=1", t); else passed++;
    endtask

    task automatic test_clamp();
        bit ok;
        int h, t, r, a;
        load_div(8'd0);
        wait_tick(8, ok);
        total++; if (bus.div_active !== 8'd2) $display("FAIL clamp0_active got=%0d exp=2", bus.div_active); else passed++;
        total++; if (bus.div_ack !== 1'b1) $display("FAIL clamp0_ack got=%b exp=1", bus.div_ack); else passed++;
        measure(2, -1, h, t, r, a);
        total++; if (h !== 2) $display("FAIL clamp0_high_halves got=%0d exp=2", h); else passed++;
        total++; if (r !== 1) $display("FAIL clamp0_rises got=%0d exp=1", r); else passed++;
        load_div(8'd1);
        wait_tick(2, ok);
        total++; if (bus.div_ack !== 1'b1) $display("FAIL clamp1_ack got=%b exp=1", bus.div_ack); else passed++;
        total++; if (bus.div_active !== 8'd2) $display("FAIL clamp1_active got=%0d exp=2", bus.div_active); else passed++;
        load_div(8'd255);
        wait_tick(2, ok);
        total++; if (bus.div_active !== 8'd255) $display("FAIL max_active got=%0d exp=255", bus.div_active); else passed++;
        measure(255, -1, h, t, r, a);
        total++; if (h !== 255) $display("FAIL max_high_halves got=%0d exp=255", h); else passed++;
        total++; if (r !== 1) $display("FAIL max_rises got=%0d exp=1", r); else passed++;
    endtask

    task automatic test_en_drop();
        bit ok;
        int h, t, r, a;
        load_div(8'd6);
        wait_tick(300, ok);
        total++; if (bus.div_active !== 8'd6) $display("FAIL drop_active got=%0d exp=6", bus.div_active); else passed++;
        measure(6, 1, h, t, r, a);
        total++; if (h !== 6) $display("FAIL drop_high_halves got=%0d exp=6", h); else passed++;
        total++; if (bus.running !== 1'b0) $display("FAIL drop_running got=%b exp=0", bus.running); else passed++;
        total++; if (bus.tick !== 1'b0) $display("FAIL drop_tick got=%b exp=0", bus.tick); else passed++;
        measure(4, -1, h, t, r, a);
        total++; if (h !== 0) $display("FAIL drop_idle_high_halves got=%0d exp=0", h); else passed++;
        total++; if (t !== 0) $display("FAIL drop_idle_ticks got=%0d exp=0", t); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int h, t, r, a;
        load_div(8'd7);
        @(posedge clk) #1;
        total++; if (bus.div_ack !== 1'b1) $display("FAIL idle_load_ack got=%b exp=1", bus.div_ack); else passed++;
        total++; if (bus.div_active !== 8'd7) $display("FAIL idle_load_active got=%0d exp=7", bus.div_active); else passed++;
        bus.en = 1'b1;
        wait_tick(4, ok);
        @(posedge clk) #1;
        total++; if (bus.clk_out !== 1'b1) $display("FAIL mid_pre_clk_out got=%b exp=1", bus.clk_out); else passed++;
        reset  = 1'b0;
        bus.en = 1'b0;
        #1;
        total++; if (bus.clk_out !== 1'b0) $display("FAIL mid_clk_out got=%b exp=0", bus.clk_out); else passed++;
        total++; if (bus.div_active !== 8'd3) $display("FAIL mid_active got=%0d exp=3", bus.div_active); else passed++;
        total++; if (bus.tick !== 1'b0) $display("FAIL mid_tick got=%b exp=0", bus.tick); else passed++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.running !== 1'b0) $display("FAIL mid_no_autostart got=%b exp=0", bus.running); else passed++;
        bus.en = 1'b1;
        wait_tick(4, ok);
        total++; if (ok !== 1'b1) $display("FAIL mid_restart_tick got=%b exp=1", ok); else passed++;
        measure(3, -1, h, t, r, a);
        total++; if (h !== 3) $display("FAIL mid_restart_high_halves got=%0d exp=3", h); else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.div_val  = '0;
        bus.div_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk) #1;
        test_div3();
        test_load4();
        test_last_write_wins();
        test_clamp();
        test_en_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
